// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader and its bench.
//   BYTE_WIDTH : width of one stream byte
//   HDR_WIDTH  : width of the word-count header and of an assembled word
//   state_t    : loader FSM state encoding
package program_loader_pkg;

    localparam int BYTE_WIDTH = 8;
    localparam int HDR_WIDTH  = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR_LO = 3'd1,
        HDR_HI = 3'd2,
        W_LO   = 3'd3,
        W_HI   = 3'd4,
        WRITE  = 3'd5,
        DONE   = 3'd6,
        ERR    = 3'd7
    } state_t;

endpackage

// File: rtl/program_loader.sv
// Program loader: receives a byte stream (16-bit word count N, low byte first,
// followed by N 16-bit words, each low byte first) and writes word i to
// instruction memory address i. The CPU is held in reset until the load
// finishes successfully.
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   start           : pulse that begins a load session (IDLE/DONE/ERR only)
//   in_valid/in_byte: byte source, transfer when in_valid && in_ready
//   in_ready        : loader is waiting for a byte
//   mem_addr/mem_data/mem_we : instruction memory write port
//   cpu_hold        : 1 until a load completes
//   done / error    : load finished / header count exceeded MEM_SIZE
module program_loader
    import program_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int MEM_SIZE   = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [BYTE_WIDTH-1:0] in_byte,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    state_t                 state_reg;
    logic [HDR_WIDTH-1:0]   count_reg;
    logic [HDR_WIDTH-1:0]   index_reg;
    logic [HDR_WIDTH-1:0]   word_reg;
    logic [ADDR_WIDTH-1:0]  mem_addr_reg;
    logic [DATA_WIDTH-1:0]  mem_data_reg;

    logic                   transfer;
    logic [HDR_WIDTH-1:0]   hdr_count;
    logic [HDR_WIDTH-1:0]   full_word;

    assign transfer  = in_valid && in_ready;
    // Values as they will look once the incoming high byte is captured, so the
    // header decision and the write registers can be set in the same edge.
    assign hdr_count = {in_byte, count_reg[BYTE_WIDTH-1:0]};
    assign full_word = {in_byte, word_reg[BYTE_WIDTH-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            index_reg    <= '0;
            word_reg     <= '0;
            mem_addr_reg <= '0;
            mem_data_reg <= '0;
        end else begin
            case (state_reg)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        index_reg <= '0;
                        state_reg <= HDR_LO;
                    end
                end
                HDR_LO: begin
                    if (transfer) begin
                        count_reg[BYTE_WIDTH-1:0] <= in_byte;
                        state_reg                 <= HDR_HI;
                    end
                end
                HDR_HI: begin
                    if (transfer) begin
                        count_reg[HDR_WIDTH-1:BYTE_WIDTH] <= in_byte;
                        if (hdr_count == '0)
                            state_reg <= DONE;
                        else if (32'(hdr_count) > MEM_SIZE)
                            state_reg <= ERR;
                        else
                            state_reg <= W_LO;
                    end
                end
                W_LO: begin
                    if (transfer) begin
                        word_reg[BYTE_WIDTH-1:0] <= in_byte;
                        state_reg                <= W_HI;
                    end
                end
                W_HI: begin
                    if (transfer) begin
                        word_reg[HDR_WIDTH-1:BYTE_WIDTH] <= in_byte;
                        // Write port registers load here so they are valid for
                        // the whole WRITE cycle and hold afterwards.
                        mem_addr_reg <= ADDR_WIDTH'(index_reg);
                        mem_data_reg <= DATA_WIDTH'(full_word);
                        state_reg    <= WRITE;
                    end
                end
                WRITE: begin
                    if (index_reg + 16'd1 == count_reg) begin
                        state_reg <= DONE;
                    end else begin
                        index_reg <= index_reg + 16'd1;
                        state_reg <= W_LO;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Moore decode of the registered state.
    assign in_ready = (state_reg == HDR_LO) || (state_reg == HDR_HI) ||
                      (state_reg == W_LO)   || (state_reg == W_HI);
    assign mem_we   = (state_reg == WRITE);
    assign mem_addr = mem_addr_reg;
    assign mem_data = mem_data_reg;
    assign cpu_hold = (state_reg != DONE);
    assign done     = (state_reg == DONE);
    assign error    = (state_reg == ERR);

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: drives byte streams, logs every memory
// write and checks outputs against hand-computed values.
module tb_program_loader;
    import program_loader_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic                  in_valid;
    logic [BYTE_WIDTH-1:0] in_byte;
    logic                  in_ready;
    logic [15:0]           mem_addr;
    logic [15:0]           mem_data;
    logic                  mem_we;
    logic                  cpu_hold;
    logic                  done;
    logic                  error;

    int total = 0;
    int bad   = 0;

    // write log filled on each rising edge with mem_we high
    int          wr_count = 0;
    logic [15:0] wr_addr [0:4095];
    logic [15:0] wr_data [0:4095];

    program_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .MEM_SIZE(1024)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_byte  (in_byte),
        .in_ready (in_ready),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_we   (mem_we),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) begin
            wr_addr[wr_count] <= mem_addr;
            wr_data[wr_count] <= mem_data;
            wr_count          <= wr_count + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Entered at a falling edge; returns at the falling edge after the transfer.
    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_byte  = b;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_byte_timeout observed=in_ready_low expected=in_ready_high byte=%0h", b);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_mem_we"},   32'(mem_we),   32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_data"}, 32'(mem_data), 32'd0);
        check({tag, "_done"},     32'(done),     32'd0);
        check({tag, "_error"},    32'(error),    32'd0);
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    endtask

    initial begin
        int          base;
        int          errs;
        logic [15:0] w;

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
        idle_cycles(2);
        // reset wins over start and in_valid in the same cycle
        start = 1'b1; in_valid = 1'b1; in_byte = 8'hFF;
        idle_cycles(1);
        start = 1'b0; in_valid = 1'b0;
        check_reset_outputs("reset");
        rst = 1'b0;
        idle_cycles(1);
        check("idle_in_ready", 32'(in_ready), 32'd0);

        // basic two-word load
        base = wr_count;
        pulse_start();
        check("hdr_in_ready", 32'(in_ready), 32'd1);
        check("hdr_cpu_hold", 32'(cpu_hold), 32'd1);
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h00);
        check("w0_mem_we",    32'(mem_we),   32'd1);
        check("w0_in_ready",  32'(in_ready), 32'd0);
        send_byte(8'h37); send_byte(8'h12);
        check("w1_mem_we",    32'(mem_we),   32'd1);
        check("w1_mem_addr",  32'(mem_addr), 32'd1);
        check("w1_mem_data",  32'(mem_data), 32'h1237);
        idle_cycles(2);
        check("basic_writes", 32'(wr_count - base), 32'd2);
        check("basic_a0", 32'(wr_addr[base]),   32'd0);
        check("basic_d0", 32'(wr_data[base]),   32'h0013);
        check("basic_a1", 32'(wr_addr[base+1]), 32'd1);
        check("basic_d1", 32'(wr_data[base+1]), 32'h1237);
        check("basic_done",     32'(done),     32'd1);
        check("basic_cpu_hold", 32'(cpu_hold), 32'd0);
        check("basic_in_ready", 32'(in_ready), 32'd0);
        check("basic_mem_we",   32'(mem_we),   32'd0);
        check("basic_hold_addr", 32'(mem_addr), 32'd1);
        check("basic_hold_data", 32'(mem_data), 32'h1237);

        // empty program
        base = wr_count;
        pulse_start();
        check("empty_done_cleared", 32'(done), 32'd0);
        send_byte(8'h00); send_byte(8'h00);
        idle_cycles(2);
        check("empty_done",   32'(done), 32'd1);
        check("empty_writes", 32'(wr_count - base), 32'd0);

        // oversize header, then recovery
        base = wr_count;
        pulse_start();
        send_byte(8'h01); send_byte(8'h04);
        idle_cycles(2);
        check("over_error",    32'(error),    32'd1);
        check("over_cpu_hold", 32'(cpu_hold), 32'd1);
        check("over_done",     32'(done),     32'd0);
        check("over_in_ready", 32'(in_ready), 32'd0);
        check("over_writes",   32'(wr_count - base), 32'd0);
        pulse_start();
        check("recover_error_cleared", 32'(error), 32'd0);
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hAD); send_byte(8'hDE);
        idle_cycles(2);
        check("recover_done",   32'(done),  32'd1);
        check("recover_error",  32'(error), 32'd0);
        check("recover_writes", 32'(wr_count - base), 32'd1);
        check("recover_d0",     32'(wr_data[base]), 32'hDEAD);

        // gapped in_valid, 3 words
        base = wr_count;
        pulse_start();
        send_byte(8'h03); idle_cycles(1); send_byte(8'h00); idle_cycles(1);
        send_byte(8'h01); idle_cycles(1); send_byte(8'hA0); idle_cycles(1);
        send_byte(8'h02); idle_cycles(1); send_byte(8'hB0); idle_cycles(1);
        send_byte(8'h03); idle_cycles(1); send_byte(8'hC0); idle_cycles(2);
        check("gap_writes", 32'(wr_count - base), 32'd3);
        check("gap_a0", 32'(wr_addr[base]),   32'd0);
        check("gap_d0", 32'(wr_data[base]),   32'hA001);
        check("gap_a1", 32'(wr_addr[base+1]), 32'd1);
        check("gap_d1", 32'(wr_data[base+1]), 32'hB002);
        check("gap_a2", 32'(wr_addr[base+2]), 32'd2);
        check("gap_d2", 32'(wr_data[base+2]), 32'hC003);
        check("gap_done", 32'(done), 32'd1);

        // reset after first word of an N=4 load
        base = wr_count;
        pulse_start();
        send_byte(8'h04); send_byte(8'h00);
        send_byte(8'h55); send_byte(8'h66);
        rst = 1'b1;
        idle_cycles(1);
        rst = 1'b0;
        check_reset_outputs("abort");
        in_valid = 1'b1; in_byte = 8'h77;
        idle_cycles(4);
        in_valid = 1'b0;
        check("abort_writes", 32'(wr_count - base), 32'd1);
        check("abort_a0",     32'(wr_addr[base]),   32'd0);
        check("abort_d0",     32'(wr_data[base]),   32'h6655);
        check("abort_idle_ready", 32'(in_ready), 32'd0);

        // full-size load with a stray start mid-stream
        base = wr_count;
        pulse_start();
        send_byte(8'h00); send_byte(8'h04);
        for (int i = 0; i < 1024; i++) begin
            w = (16'(i) * 16'h0101) ^ 16'hC3A5;
            send_byte(w[7:0]);
            if (i == 500) pulse_start();
            send_byte(w[15:8]);
        end
        idle_cycles(2);
        errs = 0;
        for (int i = 0; i < 1024; i++) begin
            w = (16'(i) * 16'h0101) ^ 16'hC3A5;
            if (wr_addr[base+i] !== 16'(i) || wr_data[base+i] !== w) errs++;
        end
        check("full_writes",    32'(wr_count - base), 32'd1024);
        check("full_contents",  32'(errs), 32'd0);
        check("full_last_addr", 32'(wr_addr[base+1023]), 32'd1023);
        check("full_done",      32'(done),     32'd1);
        check("full_cpu_hold",  32'(cpu_hold), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
